// File: rtl/qam_pkg.sv
// Shared encodings for the QAM symbol framer: FSM states, symbol constants
// and the preamble pattern helper.
package qam_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    PAYLOAD  = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [1:0] SYM_IDLE  = 2'b00;
  localparam logic [1:0] PRE_SYM_A = 2'b11;
  localparam logic [1:0] PRE_SYM_B = 2'b00;

  // Four 2-bit symbols make up one payload byte.
  localparam int SYMS_PER_BYTE = 4;

  // Preamble alternates A, B, A, ... starting at index 0.
  function automatic logic [1:0] pre_sym(input logic odd);
    return odd ? PRE_SYM_B : PRE_SYM_A;
  endfunction

endpackage

// File: rtl/qam_sym_timer.sv
// Symbol timer: counts SPS samples per symbol and the symbol index within
// the current preamble or payload byte. clear has priority over en.
module qam_sym_timer #(
  parameter int SPS   = 16,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  output logic             sym_strobe,
  output logic             end_of_symbol,
  output logic [IDX_W-1:0] idx
);

  // A 1-bit counter is kept even for SPS=1; it then simply stays at 0.
  localparam int CNT_W = (SPS > 1) ? $clog2(SPS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SPS - 1);

  logic [CNT_W-1:0] cnt;

  // Sample counter wraps at SPS-1 and advances the symbol index on wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (clear) begin
      cnt <= '0;
      idx <= '0;
    end else if (en) begin
      if (cnt == CNT_MAX) begin
        cnt <= '0;
        idx <= idx + IDX_W'(1);
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign sym_strobe    = en & (cnt == '0);
  assign end_of_symbol = en & (cnt == CNT_MAX);

endmodule

// File: rtl/qam_symbol_framer.sv
// Frames payload bytes behind a fixed preamble and serialises them into
// 2-bit symbols (MSB pair first), each held for SPS sample clocks, for the
// QAM mixer. Provides symbol strobes and frame status pulses.
//
// Handshake: a byte transfers on any rising clk edge where byte_valid and
// byte_ready are both 1. byte_ready does not depend on byte_valid; the
// upstream must hold byte_in/byte_last stable while byte_valid is 1 and
// byte_ready is 0.
module qam_symbol_framer
  import qam_pkg::*;
#(
  parameter int SPS          = 16,
  parameter int PREAMBLE_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  input  logic       byte_last,
  output logic       byte_ready,
  output logic [1:0] data_out,
  output logic       sym_valid,
  output logic       sym_strobe,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun,
  output state_t     state_dbg
);

  localparam int IDX_MAX = (PREAMBLE_LEN > SYMS_PER_BYTE) ? PREAMBLE_LEN : SYMS_PER_BYTE;
  localparam int IDX_W   = $clog2(IDX_MAX);
  localparam logic [IDX_W-1:0] PRE_LAST = IDX_W'(PREAMBLE_LEN - 1);
  localparam logic [IDX_W-1:0] PAY_LAST = IDX_W'(SYMS_PER_BYTE - 1);

  state_t           state;
  logic [7:0]       hold;
  logic             hold_full;
  logic             last_seen;
  logic [5:0]       shift;     // remaining symbols of the byte on air
  logic             active;
  logic             accept;
  logic             eos;
  logic             pre_end;
  logic             byte_end;
  logic             clear;
  logic [IDX_W-1:0] idx;

  assign active     = (state == PREAMBLE) || (state == PAYLOAD);
  assign byte_ready = (state == IDLE) | (active & ~hold_full & ~last_seen);
  assign accept     = byte_valid & byte_ready;
  assign pre_end    = eos & (state == PREAMBLE) & (idx == PRE_LAST);
  assign byte_end   = eos & (state == PAYLOAD) & (idx == PAY_LAST);
  // Restart symbol indexing outside a frame and at each section/byte boundary.
  assign clear      = ~active | pre_end | byte_end;
  assign busy       = (state != IDLE);
  assign state_dbg  = state;

  qam_sym_timer #(
    .SPS   (SPS),
    .IDX_W (IDX_W)
  ) u_timer (
    .clk           (clk),
    .rst           (rst),
    .clear         (clear),
    .en            (active),
    .sym_strobe    (sym_strobe),
    .end_of_symbol (eos),
    .idx           (idx)
  );

  // Frame FSM with registered symbol/status outputs, hold and shift registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      hold       <= '0;
      hold_full  <= 1'b0;
      last_seen  <= 1'b0;
      shift      <= '0;
      data_out   <= SYM_IDLE;
      sym_valid  <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      underrun   <= 1'b0;

      // A load below only happens with hold_full set, when byte_ready is 0,
      // so it never collides with an accept in the same cycle.
      if (accept) begin
        hold      <= byte_in;
        hold_full <= 1'b1;
        if (byte_last) last_seen <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            state     <= PREAMBLE;
            data_out  <= PRE_SYM_A;
            sym_valid <= 1'b1;
          end
        end
        PREAMBLE: begin
          if (pre_end) begin
            state     <= PAYLOAD;
            data_out  <= hold[7:6];
            shift     <= hold[5:0];
            hold_full <= 1'b0;
          end else if (eos) begin
            data_out <= pre_sym(~idx[0]);
          end
        end
        PAYLOAD: begin
          if (byte_end) begin
            if (hold_full) begin
              data_out  <= hold[7:6];
              shift     <= hold[5:0];
              hold_full <= 1'b0;
            end else if (last_seen) begin
              state      <= DONE;
              data_out   <= SYM_IDLE;
              sym_valid  <= 1'b0;
              frame_done <= 1'b1;
              last_seen  <= 1'b0;
            end else begin
              // No byte ready at a byte boundary: abandon the frame.
              state     <= IDLE;
              data_out  <= SYM_IDLE;
              sym_valid <= 1'b0;
              underrun  <= 1'b1;
              hold      <= '0;
              hold_full <= 1'b0;
              last_seen <= 1'b0;
            end
          end else if (eos) begin
            data_out <= shift[5:4];
            shift    <= {shift[3:0], 2'b00};
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qam_symbol_framer.sv
// Directed bench for qam_symbol_framer: main instance SPS=4/PREAMBLE_LEN=2,
// second instance SPS=1/PREAMBLE_LEN=1. Expected symbols go into a queue
// when a frame is driven and are popped as the DUT emits sym_valid samples.
module tb_qam_symbol_framer;
  import qam_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT 1 (SPS=4, PREAMBLE_LEN=2) ----------------
  logic [7:0] byte_in;
  logic       byte_valid, byte_last, byte_ready;
  logic [1:0] data_out;
  logic       sym_valid, sym_strobe, busy, frame_done, underrun;
  state_t     st1;

  qam_symbol_framer #(.SPS(4), .PREAMBLE_LEN(2)) dut (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_last(byte_last), .byte_ready(byte_ready), .data_out(data_out),
    .sym_valid(sym_valid), .sym_strobe(sym_strobe), .busy(busy),
    .frame_done(frame_done), .underrun(underrun), .state_dbg(st1)
  );

  // ---------------- DUT 2 (SPS=1, PREAMBLE_LEN=1) ----------------
  logic [7:0] byte_in2;
  logic       byte_valid2, byte_last2, byte_ready2;
  logic [1:0] data_out2;
  logic       sym_valid2, sym_strobe2, busy2, frame_done2, underrun2;
  state_t     st2;

  qam_symbol_framer #(.SPS(1), .PREAMBLE_LEN(1)) dut2 (
    .clk(clk), .rst(rst), .byte_in(byte_in2), .byte_valid(byte_valid2),
    .byte_last(byte_last2), .byte_ready(byte_ready2), .data_out(data_out2),
    .sym_valid(sym_valid2), .sym_strobe(sym_strobe2), .busy(busy2),
    .frame_done(frame_done2), .underrun(underrun2), .state_dbg(st2)
  );

  // ---------------- scoreboard state ----------------
  logic [2:0] exp_q[$];   // {strobe, data}
  logic [2:0] exp_q2[$];
  int n_tests = 0;
  int n_fail  = 0;
  int sv_cnt, sv_rises, sv2_cnt;
  logic prev_sv  = 1'b0;
  logic prev_sv2 = 1'b0;
  int k;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_sym(input int which, input logic [1:0] s, input int sps);
    for (int i = 0; i < sps; i++) begin
      if (which == 0) exp_q.push_back({(i == 0), s});
      else            exp_q2.push_back({(i == 0), s});
    end
  endtask

  task automatic push_preamble(input int which, input int pl, input int sps);
    for (int p = 0; p < pl; p++)
      push_sym(which, (p % 2 == 0) ? 2'b11 : 2'b00, sps);
  endtask

  task automatic push_byte(input int which, input logic [7:0] b, input int sps);
    for (int s = 0; s < 4; s++)
      push_sym(which, b[7-2*s -: 2], sps);
  endtask

  // Offer a byte to DUT 1; returns 1 time unit after the accepting edge.
  task automatic drive_byte(input logic [7:0] b, input logic last, input logic keep);
    int got;
    got = 0;
    byte_in    = b;
    byte_last  = last;
    byte_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (byte_ready) begin
        got = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!keep) begin
      byte_valid = 1'b0;
      byte_last  = 1'b0;
    end
    check("accept_wait", got, 1);
  endtask

  // Count negedges until the selected pulse is seen (bounded).
  task automatic wait_for(input int sel, input int limit, output int cnt);
    cnt = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      cnt++;
      if ((sel == 0 && frame_done) || (sel == 1 && underrun) || (sel == 2 && frame_done2))
        break;
    end
  endtask

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      if (sym_valid) begin
        sv_cnt++;
        if (!prev_sv) sv_rises++;
        check("sym_avail", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("sym", {sym_strobe, data_out}, exp_q.pop_front());
      end else begin
        check("idle_out", {sym_strobe, data_out}, 3'b000);
      end
      if (sym_valid2) begin
        sv2_cnt++;
        check("sym2_avail", exp_q2.size() != 0, 1);
        if (exp_q2.size() != 0) check("sym2", {sym_strobe2, data_out2}, exp_q2.pop_front());
      end else begin
        check("idle_out2", {sym_strobe2, data_out2}, 3'b000);
      end
    end
    prev_sv  = sym_valid;
    prev_sv2 = sym_valid2;
  end

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b0;
    byte_in = '0; byte_valid = 1'b0; byte_last = 1'b0;
    byte_in2 = '0; byte_valid2 = 1'b0; byte_last2 = 1'b0;
    sv_cnt = 0; sv_rises = 0; sv2_cnt = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_ready",    byte_ready, 1);
    check("rst_data",     data_out, 0);
    check("rst_valid",    sym_valid, 0);
    check("rst_busy",     busy, 0);
    check("rst_done",     frame_done, 0);
    check("rst_underrun", underrun, 0);
    check("rst_state",    st1, IDLE);

    // 1: single byte 0xB4 with last
    @(posedge clk); #1;
    sv_cnt = 0; sv_rises = 0;
    push_preamble(0, 2, 4);
    push_byte(0, 8'hB4, 4);
    drive_byte(8'hB4, 1'b1, 1'b0);
    @(negedge clk);
    check("t1_first_data",   data_out, 2'b11);
    check("t1_first_strobe", sym_strobe, 1);
    check("t1_first_valid",  sym_valid, 1);
    check("t1_busy",         busy, 1);
    wait_for(0, 200, k);
    check("t1_done_latency", k, 24);
    check("t1_valid_cycles", sv_cnt, 24);
    check("t1_valid_runs",   sv_rises, 1);
    check("t1_queue_empty",  exp_q.size(), 0);

    // 2: two bytes with byte_valid held high
    @(posedge clk); #1;
    sv_cnt = 0; sv_rises = 0;
    push_preamble(0, 2, 4);
    push_byte(0, 8'h1B, 4);
    push_byte(0, 8'hE4, 4);
    drive_byte(8'h1B, 1'b0, 1'b1);
    @(negedge clk);
    check("t2_ready_drop1", byte_ready, 0);
    drive_byte(8'hE4, 1'b1, 1'b0);
    @(negedge clk);
    check("t2_ready_drop2", byte_ready, 0);
    wait_for(0, 200, k);
    check("t2_done_latency", k, 31);
    check("t2_valid_cycles", sv_cnt, 40);
    check("t2_valid_runs",   sv_rises, 1);
    check("t2_queue_empty",  exp_q.size(), 0);

    // 3: second byte withheld -> underrun
    @(posedge clk); #1;
    sv_cnt = 0; sv_rises = 0;
    push_preamble(0, 2, 4);
    push_byte(0, 8'h1B, 4);
    drive_byte(8'h1B, 1'b0, 1'b0);
    wait_for(1, 200, k);
    check("t3_underrun_latency", k, 25);
    check("t3_data",  data_out, 0);
    check("t3_valid", sym_valid, 0);
    check("t3_ready", byte_ready, 1);
    check("t3_state", st1, IDLE);
    check("t3_valid_cycles", sv_cnt, 24);
    check("t3_queue_empty",  exp_q.size(), 0);
    @(negedge clk);
    check("t3_underrun_pulse", underrun, 0);

    // 4: byte_valid during DONE is held off until IDLE
    @(posedge clk); #1;
    push_preamble(0, 2, 4);
    push_byte(0, 8'h3C, 4);
    drive_byte(8'h3C, 1'b1, 1'b0);
    wait_for(0, 200, k);
    check("t4_done_latency", k, 25);
    check("t4_state_done", st1, DONE);
    sv_cnt = 0; sv_rises = 0;
    push_preamble(0, 2, 4);
    push_byte(0, 8'h96, 4);
    byte_in = 8'h96; byte_last = 1'b1; byte_valid = 1'b1;
    check("t4_ready_in_done", byte_ready, 0);
    @(negedge clk);
    check("t4_state_idle", st1, IDLE);
    check("t4_ready_idle", byte_ready, 1);
    @(posedge clk); #1;
    byte_valid = 1'b0; byte_last = 1'b0;
    @(negedge clk);
    check("t4_busy_after", busy, 1);
    check("t4_strobe_after", sym_strobe, 1);
    wait_for(0, 200, k);
    check("t4_done2_latency", k, 24);
    check("t4_valid_cycles", sv_cnt, 24);
    check("t4_queue_empty", exp_q.size(), 0);

    // 5: asynchronous reset mid-payload
    @(posedge clk); #1;
    push_preamble(0, 2, 4);
    push_byte(0, 8'hA5, 4);
    drive_byte(8'hA5, 1'b1, 1'b0);
    repeat (12) @(negedge clk);
    check("t5_in_payload", st1, PAYLOAD);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("t5_rst_data",     data_out, 0);
    check("t5_rst_valid",    sym_valid, 0);
    check("t5_rst_strobe",   sym_strobe, 0);
    check("t5_rst_busy",     busy, 0);
    check("t5_rst_done",     frame_done, 0);
    check("t5_rst_underrun", underrun, 0);
    check("t5_rst_state",    st1, IDLE);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t5_post_ready", byte_ready, 1);
    check("t5_post_busy",  busy, 0);
    @(posedge clk); #1;
    sv_cnt = 0; sv_rises = 0;
    push_preamble(0, 2, 4);
    push_byte(0, 8'h0F, 4);
    drive_byte(8'h0F, 1'b1, 1'b0);
    wait_for(0, 200, k);
    check("t5_recover_latency", k, 25);
    check("t5_recover_cycles", sv_cnt, 24);
    check("t5_queue_empty", exp_q.size(), 0);

    // 6: SPS=1, PREAMBLE_LEN=1, byte 0x5A last
    @(posedge clk); #1;
    sv2_cnt = 0;
    push_preamble(1, 1, 1);
    push_byte(1, 8'h5A, 1);
    byte_in2 = 8'h5A; byte_last2 = 1'b1; byte_valid2 = 1'b1;
    @(negedge clk);
    check("t6_ready", byte_ready2, 1);
    @(posedge clk); #1;
    byte_valid2 = 1'b0; byte_last2 = 1'b0;
    wait_for(2, 200, k);
    check("t6_done_latency", k, 6);
    check("t6_valid_cycles", sv2_cnt, 5);
    check("t6_queue_empty", exp_q2.size(), 0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
